// File: rtl/keypad_emulator_pkg.sv
// Shared keypad geometry, FSM encodings and position split helper.
// Also imported by keypad_controller benches.
package keypad_emulator_pkg;

    localparam int         KEY_ROWS    = 3;
    localparam int         KEY_COLS    = 3;
    localparam logic [3:0] KEY_POS_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HELD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } key_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Split 0..8 into row/col with constant compares, avoiding a divider.
    function automatic key_pos_t split_pos(input logic [3:0] pos);
        key_pos_t p;
        if (pos >= 4'd6) begin
            p.row = 2'd2;
            p.col = 2'(pos - 4'd6);
        end else if (pos >= 4'd3) begin
            p.row = 2'd1;
            p.col = 2'(pos - 4'd3);
        end else begin
            p.row = 2'd0;
            p.col = 2'(pos);
        end
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_lfsr8.sv
// 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1; a nonzero seed keeps it off the zero state.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    input  logic       enable,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!reset)
            q <= seed;
        else if (enable)
            q <= {1'b0, q[7:1]} ^ (q[0] ? 8'hB8 : 8'h00);
    end

endmodule

// File: rtl/keypad_emulator.sv
// 3x3 membrane keypad model: presses one key per command with LFSR contact bounce,
// driving active-low rows from the controller's active-low column strobes.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int         BOUNCE_CYCLES = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  column,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_position,
    input  logic [15:0] cmd_hold,
    output logic        cmd_err,
    output logic        busy,
    output logic        done,
    output logic [2:0]  row
);

    localparam logic [15:0] BOUNCE_LEN = 16'(BOUNCE_CYCLES);

    key_state_t  state;
    logic [15:0] dwell;
    logic [15:0] hold_len;
    logic [1:0]  pos_row;
    logic [1:0]  pos_col;
    logic        contact;
    logic [7:0]  lfsr_q;
    logic        col_driven;
    key_pos_t    cmd_split;

    lfsr8 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .seed   (LFSR_SEED),
        .enable (1'b1),
        .q      (lfsr_q)
    );

    assign cmd_split = split_pos(cmd_position);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            dwell    <= '0;
            hold_len <= '0;
            pos_row  <= '0;
            pos_col  <= '0;
            contact  <= 1'b0;
            done     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            dwell   <= dwell - 16'd1;
            case (state)
                IDLE: begin
                    contact <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_position > KEY_POS_MAX) begin
                            cmd_err <= 1'b1;
                        end else begin
                            pos_row  <= cmd_split.row;
                            pos_col  <= cmd_split.col;
                            hold_len <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
                            dwell    <= BOUNCE_LEN;
                            contact  <= lfsr_q[0];
                            state    <= PRESS_BOUNCE;
                        end
                    end
                end
                PRESS_BOUNCE: begin
                    if (dwell == 16'd1) begin
                        dwell   <= hold_len;
                        contact <= 1'b1;
                        state   <= HELD;
                    end else begin
                        contact <= lfsr_q[0];
                    end
                end
                HELD: begin
                    if (dwell == 16'd1) begin
                        dwell   <= BOUNCE_LEN;
                        contact <= lfsr_q[0];
                        state   <= RELEASE_BOUNCE;
                    end else begin
                        contact <= 1'b1;
                    end
                end
                RELEASE_BOUNCE: begin
                    if (dwell == 16'd1) begin
                        contact <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        contact <= lfsr_q[0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (pos_col)
            2'd0:    col_driven = ~column[0];
            2'd1:    col_driven = ~column[1];
            2'd2:    col_driven = ~column[2];
            default: col_driven = 1'b0;
        endcase
    end

    // Combinational path so the controller sees its strobe reflected in the same cycle.
    always_comb begin
        for (int r = 0; r < KEY_ROWS; r++)
            row[r] = ~(contact & (pos_row == 2'(r)) & col_driven);
    end

endmodule
